// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback-trace capture buffer.
// The entry struct reflects the default field widths of wb_trace_buffer.
package wb_trace_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  localparam int unsigned DEF_SEQ_W  = 32;
  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;

  typedef struct packed {
    logic [DEF_SEQ_W-1:0]  seq;
    logic [DEF_PC_W-1:0]   pc;
    logic                  ena;
    logic [DEF_REG_W-1:0]  regno;
    logic [DEF_DATA_W-1:0] value;
  } wb_trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO with explicit occupancy count.
// A write is accepted while full only when a read happens on the same edge.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_rd;
  logic             do_wr;

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_wr) tail <= tail + 1'b1;
      if (do_rd) head <= head + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[tail] <= wr_data;
  end

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[head];

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback-trace capture buffer: tags retires with a sequence number and queues them.
// Define WB_TRACE_FILTER_EN to capture only register-writing retires to x1..x31.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned SEQ_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_have_inst,
  input  logic [PC_W-1:0]         in_pc,
  input  logic                    in_ena,
  input  logic [REG_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]       in_value,
  input  logic                    freeze,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEQ_W-1:0]        out_seq,
  output logic [PC_W-1:0]         out_pc,
  output logic                    out_ena,
  output logic [REG_W-1:0]        out_reg,
  output logic [DATA_W-1:0]       out_value,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  // Parameter-width view of wb_trace_entry_t.
  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [PC_W-1:0]   pc;
    logic              ena;
    logic [REG_W-1:0]  regno;
    logic [DATA_W-1:0] value;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  logic               ret;
  logic               push;
  logic               pop;
  logic               drop;
  logic [SEQ_W-1:0]   seq;
  entry_t             wr_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] head_bits;

`ifdef WB_TRACE_FILTER_EN
  assign ret = in_have_inst & in_ena & (in_reg != '0);
`else
  assign ret = in_have_inst;
`endif

  assign push      = ret & ~freeze;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign drop      = push & full & ~pop;

  always_comb begin
    wr_entry       = '0;
    wr_entry.seq   = seq;
    wr_entry.pc    = in_pc;
    wr_entry.ena   = in_ena;
    wr_entry.regno = in_reg;
    wr_entry.value = in_value;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head_bits),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // FIFO already returns zero when empty, so the fields need no extra gating.
  assign head_entry = entry_t'(head_bits);
  assign out_seq    = head_entry.seq;
  assign out_pc     = head_entry.pc;
  assign out_ena    = head_entry.ena;
  assign out_reg    = head_entry.regno;
  assign out_value  = head_entry.value;

  // Sequence advances on every retire, captured or not, so gaps reveal losses.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (in_have_inst) seq <= seq + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: expected entries are queued at stimulus time
// and a negedge monitor compares every handshake against the queue head.
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_have_inst = 1'b0;
  logic [31:0] in_pc = '0;
  logic        in_ena = 1'b0;
  logic [4:0]  in_reg = '0;
  logic [31:0] in_value = '0;
  logic        freeze = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_seq;
  logic [31:0] out_pc;
  logic        out_ena;
  logic [4:0]  out_reg;
  logic [31:0] out_value;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  wb_trace_entry_t sb[$];
  wb_trace_entry_t mon_got;
  wb_trace_entry_t mon_exp;

`ifdef WB_TRACE_FILTER_EN
  localparam logic FILT = 1'b1;
`else
  localparam logic FILT = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_trace_buffer #(
    .DEPTH  (DEPTH),
    .PC_W   (32),
    .DATA_W (32),
    .REG_W  (5),
    .SEQ_W  (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_have_inst (in_have_inst),
    .in_pc        (in_pc),
    .in_ena       (in_ena),
    .in_reg       (in_reg),
    .in_value     (in_value),
    .freeze       (freeze),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_seq      (out_seq),
    .out_pc       (out_pc),
    .out_ena      (out_ena),
    .out_reg      (out_reg),
    .out_value    (out_value),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  // Inputs change #1 after posedge, so the negedge view is what the next edge samples.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_got.seq   = out_seq;
      mon_got.pc    = out_pc;
      mon_got.ena   = out_ena;
      mon_got.regno = out_reg;
      mon_got.value = out_value;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got 0x%0h required no entry", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL pop_entry: got 0x%0h required 0x%0h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic retire(input logic [31:0] pc, input logic ena, input logic [4:0] regno,
                        input logic [31:0] seq_exp, input logic expect_push);
    wb_trace_entry_t e;
    in_pc        = pc;
    in_ena       = ena;
    in_reg       = regno;
    in_value     = pc ^ 32'hDEAD_0000;
    in_have_inst = 1'b1;
    if (expect_push) begin
      e.seq   = seq_exp;
      e.pc    = pc;
      e.ena   = ena;
      e.regno = regno;
      e.value = pc ^ 32'hDEAD_0000;
      sb.push_back(e);
    end
    step(1);
    in_have_inst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    step(2);
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_out_pc", out_pc, 0);
    rst = 1'b0;

    // Three retires held, then drained back-to-back.
    for (int i = 0; i < 3; i++) retire(32'(i * 4), 1'b1, 5'(i + 1), 32'(i), 1'b1);
    check("t1_count", count, 3);
    check("t1_head_seq", out_seq, 0);
    check("t1_head_pc", out_pc, 0);
    out_ready = 1'b1;
    step(3);
    check("t1_empty", empty, 1);
    check("t1_zero_seq", out_seq, 0);
    check("t1_zero_value", out_value, 0);
    out_ready = 1'b0;

    // Overflow: 20 retires into 16 slots.
    do_reset();
    for (int i = 0; i < 20; i++) retire(32'h1000 + 32'(i * 4), 1'b1, 5'd3, 32'(i), i < DEPTH);
    check("t2_full", full, 1);
    check("t2_count", count, 16);
    check("t2_overflow", overflow, 1);
    check("t2_drop", drop_cnt, 4);
    out_ready = 1'b1;
    step(DEPTH);
    check("t2_empty", empty, 1);
    out_ready = 1'b0;

    // Full buffer with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) retire(32'h2000 + 32'(i * 4), 1'b1, 5'd7, 32'(i), 1'b1);
    check("t3_full", full, 1);
    out_ready = 1'b1;
    for (int i = DEPTH; i < DEPTH + 10; i++) begin
      retire(32'h2000 + 32'(i * 4), 1'b0, 5'd9, 32'(i), 1'b1);
      check("t3_count", count, 16);
    end
    check("t3_drop", drop_cnt, 0);
    check("t3_overflow", overflow, 0);
    step(DEPTH);
    check("t3_empty", empty, 1);
    out_ready = 1'b0;

    // Filtering: x0 write, x5 write, store.
    do_reset();
    retire(32'h100, 1'b1, 5'd0, 32'd0, !FILT);
    retire(32'h104, 1'b1, 5'd5, 32'd1, 1'b1);
    retire(32'h108, 1'b0, 5'd7, 32'd2, !FILT);
    check("t4_count", count, FILT ? 1 : 3);
    check("t4_head_seq", out_seq, FILT ? 1 : 0);
    out_ready = 1'b1;
    step(4);
    check("t4_empty", empty, 1);
    out_ready = 1'b0;

    // Freeze suppresses capture but not sequence advance; then reset mid-stream.
    do_reset();
    freeze = 1'b1;
    retire(32'h300, 1'b1, 5'd1, 32'd0, 1'b0);
    retire(32'h304, 1'b1, 5'd1, 32'd1, 1'b0);
    freeze = 1'b0;
    retire(32'h308, 1'b1, 5'd2, 32'd2, 1'b1);
    check("t5_count", count, 1);
    check("t5_head_seq", out_seq, 2);
    retire(32'h30C, 1'b1, 5'd2, 32'd3, 1'b1);
    retire(32'h310, 1'b1, 5'd2, 32'd4, 1'b1);
    check("t5_count3", count, 3);
    in_have_inst = 1'b1;
    do_reset();
    in_have_inst = 1'b0;
    check("t5_rst_count", count, 0);
    check("t5_rst_valid", out_valid, 0);
    retire(32'h400, 1'b1, 5'd4, 32'd0, 1'b1);
    check("t5_seq_restart", out_seq, 0);
    out_ready = 1'b1;
    step(1);
    check("t5_empty", empty, 1);
    out_ready = 1'b0;

    // drop_cnt saturation over 70000 drops.
    do_reset();
    for (int i = 0; i < DEPTH; i++) retire(32'h5000 + 32'(i * 4), 1'b1, 5'd6, 32'(i), 1'b1);
    in_pc        = 32'h6000;
    in_ena       = 1'b1;
    in_reg       = 5'd6;
    in_have_inst = 1'b1;
    step(65534);
    check("t6_drop_fffe", drop_cnt, 16'hFFFE);
    step(1);
    check("t6_drop_ffff", drop_cnt, 16'hFFFF);
    step(4465);
    in_have_inst = 1'b0;
    check("t6_drop_sat", drop_cnt, 16'hFFFF);
    check("t6_overflow", overflow, 1);
    check("t6_count", count, 16);
    out_ready = 1'b1;
    step(DEPTH);
    check("t6_empty", empty, 1);
    out_ready = 1'b0;

    step(2);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Parametrised writeback-trace capture buffer for the miniRV CPU family. It samples the `debug_wb_*` commit stream once per clock and tags each retired instruction with a sequence number. Entries go into a FIFO that a trace comparator or UART dumper drains through a valid/ready port. Unlike the fixed single-cycle trace hookup, it accepts `have_inst = 0` bubbles from pipelined cores, buffers bursts, detects and counts overflow, and can freeze capture.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `PC_W`, 32: PC width.
- `DATA_W`, 32: writeback value width.
- `REG_W`, 5: register index width.
- `SEQ_W`, 32: sequence counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_have_inst`  in  1: an instruction retires this cycle.
- `in_pc`  in  PC_W: retiring PC.
- `in_ena`  in  1: register-file write enable.
- `in_reg`  in  REG_W: destination register.
- `in_value`  in  DATA_W: value written.
- `freeze`  in  1: when high, no new entries are captured; the sequence counter still advances.
- `out_valid`  out  1: head entry available.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_seq`  out  SEQ_W: head sequence number.
- `out_pc`, `out_ena`, `out_reg`, `out_value`  out: head entry fields.
- `count`  out  $clog2(DEPTH)+1: occupancy.
- `full`, `empty`  out  1: occupancy flags.
- `overflow`  out  1: sticky; an entry was lost.
- `drop_cnt`  out  16: saturating count of lost entries.

## Operation
- Qualified retire: `ret = in_have_inst`. With `WB_TRACE_FILTER_EN`, `ret = in_have_inst & in_ena & (in_reg != 0)`.
- Sequence counter `seq`:
  - Increments by 1 on every `in_have_inst` cycle, filtered or not. Wraps modulo 2^SEQ_W.
  - Each entry stores the pre-increment value.
  - Gaps in `out_seq` therefore expose filtered or dropped instructions.
- Push request: `push = ret & ~freeze`. Pop: `pop = out_valid & out_ready`.
- Push with `!full`: entry written at the tail.
- Push with `full` and `pop`: the push is accepted and `count` is unchanged.
- Push with `full` and no `pop`: entry discarded, `overflow` ← 1, `drop_cnt` += 1, saturating at 16'hFFFF.
- Pop when empty: impossible by construction, since `out_valid` = 0.
- Head/tail pointers have log2(DEPTH) bits and wrap naturally. `count` is tracked explicitly, so full and empty are unambiguous.
- `out_*` fields read 0 whenever `empty`. Otherwise they show the head entry (first-word fall-through).
- `full = (count == DEPTH)`, `empty = (count == 0)`.
- Reset clears:
  - pointers, `count`, `seq`, `overflow`, `drop_cnt`;
  - in-flight entries are lost.
- Reset values of outputs: `out_valid` 0, all `out_*` 0, `count` 0, `full` 0, `empty` 1, `overflow` 0, `drop_cnt` 0.
- Reset mid-operation wins over any simultaneous push or pop.

## Timing
- Capture latency: a push sampled at edge N gives `out_valid` = 1 and valid fields during cycle N+1 (1 cycle).
- Pop at edge N: the next entry, if any, is presented in cycle N+1. This sustains 1 entry/clock throughput.
- `count`, `full`, `empty`, `overflow` and `drop_cnt` are registered and reflect all edges up to and including N.
- Handshake: `out_*` stay stable while `out_valid & ~out_ready`. The consumer may hold `out_ready` high continuously.
- `freeze` takes effect in the same cycle it is sampled. There is no pipeline skew.

## Configuration
- `WB_TRACE_FILTER_EN` defined: only register-writing retires to x1–x31 are captured.
- Not defined: every `in_have_inst` cycle is captured, including stores, branches and writes to x0.
- The sequence counter behaves identically in both builds.

## Structure
- Package `wb_trace_pkg`:
  - `wb_trace_entry_t` packed struct {seq, pc, ena, reg, value};
  - `DROP_CNT_W = 16` constant.
- Sub-module `trace_fifo`:
  - generic synchronous FWFT FIFO (`DEPTH`, `WIDTH`) holding the pointers, `count` and storage;
  - the top level holds seq, filter, overflow and drop logic.

## Test plan
- Reset, then 3 retires with PC 0x0, 0x4, 0x8 and `out_ready` = 0 → `count` = 3; head seq 0 PC 0x0. Then `out_ready` = 1 → seq 0, 1, 2 drain on consecutive cycles, then `empty` = 1.
- DEPTH = 16, 20 retires with no pop → `full` = 1, `overflow` = 1, `drop_cnt` = 4; drained seqs are 0..15.
- Full buffer with simultaneous push and pop for 10 cycles → `count` stays 16, `drop_cnt` stays 0, seqs contiguous.
- Filter build: retires to x0, to x5 with ena = 1, and a store with ena = 0 → a single entry, seq 1, reg 5.
- `freeze` = 1 for 2 retires, then release and retire once → one entry with seq 2. Then assert `rst` mid-stream with data queued → next cycle `count` = 0 and `out_valid` = 0, and the next retire gets seq 0.
- `drop_cnt` saturation: 70000 forced drops → `drop_cnt` = 16'hFFFF, with no wrap.
